// File: rtl/mem_lsu_pkg.sv
// lsu_types: shared types for the mem_lsu load/store unit (states, access sizes,
// load/store funct3 codes and the base byte-enable helper).
package lsu_types;

  localparam int unsigned MAX_BYTES = 8;

  typedef enum logic [1:0] {
    LSU_IDLE   = 2'd0,
    LSU_FIRST  = 2'd1,
    LSU_SECOND = 2'd2,
    LSU_DONE   = 2'd3
  } lsu_state_t;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } lsu_size_t;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    ld  = 3'b011,
    lbu = 3'b100,
    lhu = 3'b101,
    lwu = 3'b110
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010,
    sd = 3'b011
  } store_funct3_t;

  // Base byte enable for an access of the given size, lane 0 aligned.
  function automatic logic [MAX_BYTES-1:0] size_mask(lsu_size_t size);
    case (size)
      SIZE_B:  return 8'h01;
      SIZE_H:  return 8'h03;
      SIZE_W:  return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic int unsigned size_bytes(lsu_size_t size);
    return 32'd1 << size;
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// mem_lsu_if: dcache command/response bus between the load/store unit and the dcache.
interface mem_lsu_if #(
  parameter int unsigned XLEN = 32
);
  localparam int unsigned NBYTES = XLEN / 8;

  logic              dcache_read;
  logic              dcache_write;
  logic [XLEN-1:0]   dcache_addr;
  logic [NBYTES-1:0] dcache_byte_enable;
  logic [XLEN-1:0]   dcache_wdata;
  logic [XLEN-1:0]   dcache_rdata;
  logic              dcache_resp;

  modport master (
    output dcache_read, dcache_write, dcache_addr, dcache_byte_enable, dcache_wdata,
    input  dcache_rdata, dcache_resp
  );

  modport slave (
    input  dcache_read, dcache_write, dcache_addr, dcache_byte_enable, dcache_wdata,
    output dcache_rdata, dcache_resp
  );
endinterface

// File: rtl/mem_lsu_align.sv
// lsu_align: combinational lane alignment -- store shift and byte enables for the
// low/high aligned words, misalignment detect, and load merge/shift/extend.
module lsu_align
  import lsu_types::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NBYTES = XLEN / 8
) (
  input  logic [XLEN-1:0]   addr,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   sdata,
  input  logic [XLEN-1:0]   lo_rdata,
  input  logic [XLEN-1:0]   hi_rdata,
  output logic [XLEN-1:0]   lo_addr,
  output logic [XLEN-1:0]   hi_addr,
  output logic [NBYTES-1:0] lo_be,
  output logic [NBYTES-1:0] hi_be,
  output logic [XLEN-1:0]   lo_wdata,
  output logic [XLEN-1:0]   hi_wdata,
  output logic              misaligned,
  output logic [XLEN-1:0]   ldata
);
  localparam int unsigned OFFW = $clog2(NBYTES);
  localparam lsu_size_t   FULL = (XLEN == 64) ? SIZE_D : SIZE_W;

  logic [OFFW-1:0]   off;
  logic [OFFW:0]     span;
  lsu_size_t         size;
  logic              is_unsigned;
  logic [NBYTES-1:0] mask;
  logic [2*XLEN-1:0] merged;
  logic [XLEN-1:0]   shifted;

  always_comb begin
    off         = addr[OFFW-1:0];
    span        = (OFFW+1)'(NBYTES) - (OFFW+1)'(off);
    size        = FULL;
    is_unsigned = 1'b0;
    // Unrecognised codes (and ld/lwu on a 32-bit datapath) are full-width.
    case (funct3)
      lb:  size = SIZE_B;
      lh:  size = SIZE_H;
      lw:  size = SIZE_W;
      lbu: begin size = SIZE_B; is_unsigned = 1'b1; end
      lhu: begin size = SIZE_H; is_unsigned = 1'b1; end
      lwu: if (XLEN == 64) begin size = SIZE_W; is_unsigned = 1'b1; end
      default: size = FULL;
    endcase

    mask       = NBYTES'(size_mask(size));
    misaligned = (32'(off) + size_bytes(size)) > NBYTES;

    lo_addr  = addr & ~XLEN'(NBYTES - 1);
    hi_addr  = lo_addr + XLEN'(NBYTES);
    lo_be    = mask << off;
    hi_be    = mask >> span;
    lo_wdata = sdata << {off, 3'b000};
    hi_wdata = sdata >> {span, 3'b000};

    merged  = {hi_rdata, lo_rdata} >> {off, 3'b000};
    shifted = merged[XLEN-1:0];
    case (size)
      SIZE_B:  ldata = is_unsigned ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
      SIZE_H:  ldata = is_unsigned ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
      SIZE_W:  ldata = is_unsigned ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
      default: ldata = shifted;
    endcase
  end
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit -- FSM, request latch and low-part capture.
// Define LSU_MISALIGNED_SPLIT_EN to split misaligned accesses; otherwise they trap.
module mem_lsu
  import lsu_types::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NBYTES = XLEN / 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic            req_read,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_rs2,
  input  logic            fwd_sel,
  input  logic [XLEN-1:0] fwd_data,
  mem_lsu_if.master       dc,
  output logic            mem_stall,
  output logic [XLEN-1:0] mem_rdata,
  output logic            rdata_valid,
  output logic            misaligned_exc
);
  localparam logic [1:0] IDLE   = LSU_IDLE;
  localparam logic [1:0] FIRST  = LSU_FIRST;
  localparam logic [1:0] SECOND = LSU_SECOND;
  localparam logic [1:0] DONE   = LSU_DONE;

  logic [1:0]        state, state_d;
  logic [XLEN-1:0]   lat_addr, lat_data, lo_q;
  logic [2:0]        lat_funct3;
  logic              lat_read, lat_write;
  logic              is_mem;
  logic [XLEN-1:0]   src_addr, src_data, lo_rdata;
  logic [2:0]        src_funct3;
  logic              src_read, src_write;
  logic [XLEN-1:0]   lo_addr, hi_addr, lo_wdata, hi_wdata, ld_result;
  logic [NBYTES-1:0] lo_be, hi_be;
  logic              misaligned;
  logic              cmd_rd_d, cmd_wr_d, trap_d, ld_done;
  logic [XLEN-1:0]   addr_d, wdata_d;
  logic [NBYTES-1:0] be_d;

  assign is_mem    = req_valid & (req_read | req_write);
  assign mem_stall = ~rst & is_mem & (state != DONE);

  // In IDLE the aligner sees the live request so the first command registers at accept.
  always_comb begin
    if (state == IDLE) begin
      src_addr   = req_addr;
      src_funct3 = req_funct3;
      src_read   = req_read;
      src_write  = req_write;
      src_data   = fwd_sel ? fwd_data : req_rs2;
    end else begin
      src_addr   = lat_addr;
      src_funct3 = lat_funct3;
      src_read   = lat_read;
      src_write  = lat_write;
      src_data   = lat_data;
    end
    lo_rdata = (state == FIRST) ? dc.dcache_rdata : lo_q;
  end

  lsu_align #(.XLEN(XLEN), .NBYTES(NBYTES)) u_align (
    .addr       (src_addr),
    .funct3     (src_funct3),
    .sdata      (src_data),
    .lo_rdata   (lo_rdata),
    .hi_rdata   (dc.dcache_rdata),
    .lo_addr    (lo_addr),
    .hi_addr    (hi_addr),
    .lo_be      (lo_be),
    .hi_be      (hi_be),
    .lo_wdata   (lo_wdata),
    .hi_wdata   (hi_wdata),
    .misaligned (misaligned),
    .ldata      (ld_result)
  );

  always_comb begin
    state_d  = state;
    trap_d   = 1'b0;
    cmd_rd_d = 1'b0;
    cmd_wr_d = 1'b0;
    addr_d   = '0;
    be_d     = '0;
    wdata_d  = '0;
    case (state)
      IDLE: if (is_mem) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
        state_d = FIRST;
`else
        if (misaligned) begin
          state_d = DONE;
          trap_d  = 1'b1;
        end else begin
          state_d = FIRST;
        end
`endif
      end
      FIRST: if (dc.dcache_resp) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
        state_d = misaligned ? SECOND : DONE;
`else
        state_d = DONE;
`endif
      end
      SECOND: if (dc.dcache_resp) state_d = DONE;
      default: state_d = IDLE;
    endcase

    // Command registers carry the command for the state being entered.
    if (state_d == FIRST) begin
      cmd_rd_d = src_read;
      cmd_wr_d = src_write;
      addr_d   = lo_addr;
      be_d     = lo_be;
      wdata_d  = lo_wdata;
    end else if (state_d == SECOND) begin
      cmd_rd_d = src_read;
      cmd_wr_d = src_write;
      addr_d   = hi_addr;
      be_d     = hi_be;
      wdata_d  = hi_wdata;
    end

    ld_done = ((state == FIRST) || (state == SECOND)) && (state_d == DONE) && src_read;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= IDLE;
      lat_addr              <= '0;
      lat_data              <= '0;
      lat_funct3            <= '0;
      lat_read              <= 1'b0;
      lat_write             <= 1'b0;
      lo_q                  <= '0;
      dc.dcache_read        <= 1'b0;
      dc.dcache_write       <= 1'b0;
      dc.dcache_addr        <= '0;
      dc.dcache_byte_enable <= '0;
      dc.dcache_wdata       <= '0;
      mem_rdata             <= '0;
      rdata_valid           <= 1'b0;
      misaligned_exc        <= 1'b0;
    end else begin
      state <= state_d;
      if ((state == IDLE) && is_mem) begin
        lat_addr   <= src_addr;
        lat_data   <= src_data;
        lat_funct3 <= src_funct3;
        lat_read   <= src_read;
        lat_write  <= src_write;
      end
      if ((state == FIRST) && dc.dcache_resp) lo_q <= dc.dcache_rdata;
      dc.dcache_read        <= cmd_rd_d;
      dc.dcache_write       <= cmd_wr_d;
      dc.dcache_addr        <= addr_d;
      dc.dcache_byte_enable <= be_d;
      dc.dcache_wdata       <= wdata_d;
      rdata_valid           <= ld_done;
      if (ld_done) mem_rdata <= ld_result;
      misaligned_exc        <= trap_d;
    end
  end
endmodule
